// File: rtl/prach_hb2_int_ch.sv
// Halfband x2 interpolator for the TDM PRACH channel path: 4-tap FIR phase (dp1) and centre-tap phase (dp2).
// Optional output clamp on dp1 when PRACH_HB2_INT_SAT_EN is defined; default build wraps.
module prach_hb2_int_ch #(
    parameter int NUM_CHANNEL = 32,
    parameter int COE0        = -4249,
    parameter int COE1        = 37013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] din_dq,
    input  logic [7:0]  din_chn,
    input  logic        sync_in,
    output logic [15:0] dout_dp1,
    output logic [15:0] dout_dp2,
    output logic [7:0]  dout_chn,
    output logic        sync_out
);

    localparam int DL_LEN = 3 * NUM_CHANNEL;
    localparam logic signed [17:0] C0 = 18'(COE0);
    localparam logic signed [17:0] C1 = 18'(COE1);

    // x0 is taken straight from din_dq, so the stored line is 3*N words; the S1 x0 register is the extra word.
    logic signed [15:0] dl_q [DL_LEN];
    logic signed [15:0] dl_d [DL_LEN];

    logic signed [15:0] x0_q, x1_q, x2_q, x3_q;
    logic signed [15:0] x0_d, x1_d, x2_d, x3_d;
    logic signed [16:0] s03_q, s12_q, s03_d, s12_d;
    logic signed [34:0] p0_q, p1_q, p0_d, p1_d;
    logic signed [35:0] acc_q, acc_d;
    logic        [15:0] dp1_q, dp1_d;

    logic [4:0][15:0] dp2_q, dp2_d;
    logic [4:0][7:0]  chn_q, chn_d;
    logic [4:0]       sync_q, sync_d;

    always_comb begin
        dl_d[0] = din_dq;
        for (int unsigned k = 1; k < DL_LEN; k++) begin
            dl_d[k] = dl_q[k-1];
        end
    end

    // Delay line carries no reset so it can map to distributed RAM.
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < DL_LEN; k++) begin
            dl_q[k] <= dl_d[k];
        end
    end

    always_comb begin
        x0_d   = din_dq;
        x1_d   = dl_q[NUM_CHANNEL-1];
        x2_d   = dl_q[2*NUM_CHANNEL-1];
        x3_d   = dl_q[3*NUM_CHANNEL-1];
        s03_d  = 17'(x0_q) + 17'(x3_q);
        s12_d  = 17'(x1_q) + 17'(x2_q);
        p0_d   = 35'(s03_q) * 35'(C0);
        p1_d   = 35'(s12_q) * 35'(C1);
        acc_d  = 36'(p0_q) + 36'(p1_q) + 36'sd32768;
        dp2_d  = {dp2_q[3:0], x1_d};
        chn_d  = {chn_q[3:0], din_chn};
        sync_d = {sync_q[3:0], sync_in};
`ifdef PRACH_HB2_INT_SAT_EN
        // acc[35:31] all equal means acc >>> 16 fits in int16.
        if ((acc_q[35:31] == 5'b00000) || (acc_q[35:31] == 5'b11111)) begin
            dp1_d = acc_q[31:16];
        end else if (acc_q[35]) begin
            dp1_d = 16'h8000;
        end else begin
            dp1_d = 16'h7fff;
        end
`else
        dp1_d = acc_q[31:16];
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x0_q   <= '0;
            x1_q   <= '0;
            x2_q   <= '0;
            x3_q   <= '0;
            s03_q  <= '0;
            s12_q  <= '0;
            p0_q   <= '0;
            p1_q   <= '0;
            acc_q  <= '0;
            dp1_q  <= '0;
            dp2_q  <= '0;
            chn_q  <= '0;
            sync_q <= '0;
        end else begin
            x0_q   <= x0_d;
            x1_q   <= x1_d;
            x2_q   <= x2_d;
            x3_q   <= x3_d;
            s03_q  <= s03_d;
            s12_q  <= s12_d;
            p0_q   <= p0_d;
            p1_q   <= p1_d;
            acc_q  <= acc_d;
            dp1_q  <= dp1_d;
            dp2_q  <= dp2_d;
            chn_q  <= chn_d;
            sync_q <= sync_d;
        end
    end

    assign dout_dp1 = dp1_q;
    assign dout_dp2 = dp2_q[4];
    assign dout_chn = chn_q[4];
    assign sync_out = sync_q[4];

endmodule

// File: tb/tb_prach_hb2_int_ch.sv
// Scoreboard bench for prach_hb2_int_ch: driver queues hand-computed expectations, negedge monitor checks them.
// Honours PRACH_HB2_INT_SAT_EN for the overflow expectation.
module tb_prach_hb2_int_ch;

    logic               clk;
    logic               rst_n;
    logic signed [15:0] din_dq;
    logic [7:0]         din_chn;
    logic               sync_in;
    logic signed [15:0] dout_dp1;
    logic signed [15:0] dout_dp2;
    logic [7:0]         dout_chn;
    logic               sync_out;

    prach_hb2_int_ch #(.NUM_CHANNEL(32), .COE0(-4249), .COE1(37013)) dut (
        .clk(clk), .rst_n(rst_n), .din_dq(din_dq), .din_chn(din_chn), .sync_in(sync_in),
        .dout_dp1(dout_dp1), .dout_dp2(dout_dp2), .dout_chn(dout_chn), .sync_out(sync_out)
    );

    typedef struct {
        int                 due;
        bit                 cdp;
        logic signed [15:0] e1;
        logic signed [15:0] e2;
        bit                 cctl;
        logic [7:0]         ec;
        logic               es;
        string              tag;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

`ifdef PRACH_HB2_INT_SAT_EN
    localparam int OVF_EXP = 32767;
`else
    localparam int OVF_EXP = -24275;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string nm, input int act, input int want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got %0d want %0d", nm, cyc, act, want);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.due < cyc) begin
                cmp({e.tag, "_late"}, cyc, e.due);
            end else begin
                if (e.cdp) begin
                    cmp({e.tag, "_dp1"}, int'(dout_dp1), int'(e.e1));
                    cmp({e.tag, "_dp2"}, int'(dout_dp2), int'(e.e2));
                end
                if (e.cctl) begin
                    cmp({e.tag, "_chn"}, int'(dout_chn), int'(e.ec));
                    cmp({e.tag, "_sync"}, int'(sync_out), int'(e.es));
                end
            end
        end
    end

    task automatic drive(input string tag, input logic rst, input int d, input int c, input logic s,
                         input bit cdp, input int e1, input int e2,
                         input bit cctl, input int ec, input logic es);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n   = rst;
        din_dq  = 16'(d);
        din_chn = 8'(c);
        sync_in = s;
        e.due = cyc + 5;
        e.cdp = cdp;
        e.e1 = 16'(e1);
        e.e2 = 16'(e2);
        e.cctl = cctl;
        e.ec = 8'(ec);
        e.es = es;
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic flush(input int n);
        for (int i = 0; i < n; i++) begin
            drive("flush", 1'b1, 0, i % 32, 1'b0, 1'b0, 0, 0, 1'b1, i % 32, 1'b0);
        end
    endtask

    // Impulse of 16384 entered at index b: outer taps -1062, inner taps 9253, one channel-period apart.
    function automatic int imp(input int i, input int b);
        if (i == b || i == b + 96) return -1062;
        if (i == b + 32 || i == b + 64) return 9253;
        return 0;
    endfunction

    initial begin
        int d;
        rst_n = 1'b0;
        din_dq = '0;
        din_chn = '0;
        sync_in = 1'b0;

        for (int i = 0; i < 8; i++) begin
            drive("reset", 1'b0, 1234, 7, 1'b1, 1'b1, 0, 0, 1'b1, 0, 1'b0);
        end

        flush(101);
        for (int i = 0; i < 105; i++) begin
            d = (i == 0) ? 16384 : 0;
            drive("impulse", 1'b1, d, i % 32, 1'b0, 1'b1, imp(i, 0), (i == 32) ? 16384 : 0, 1'b1, i % 32, 1'b0);
        end

        flush(101);
        for (int i = 0; i < 105; i++) begin
            d = (i == 5) ? 16384 : 0;
            drive("isolate", 1'b1, d, i % 32, 1'b0, 1'b1, imp(i, 5), (i == 37) ? 16384 : 0, 1'b1, i % 32, 1'b0);
        end

        flush(101);
        for (int i = 0; i < 128; i++) begin
            drive("dc", 1'b1, 32767, i % 32, 1'b0, i >= 96, 32763, 32767, 1'b1, i % 32, 1'b0);
        end

        flush(101);
        for (int i = 0; i < 97; i++) begin
            if (i == 0 || i == 96) d = -32768;
            else if (i == 32 || i == 64) d = 32767;
            else d = 0;
            drive("ovf", 1'b1, d, i % 32, 1'b0, i == 96, OVF_EXP, 32767, 1'b1, i % 32, 1'b0);
        end

        flush(101);
        for (int i = 0; i < 40; i++) begin
            d = (i < 32) ? i : 200 + i;
            drive("syncchn", 1'b1, 100, d, i == 3, 1'b0, 0, 0, 1'b1, d, i == 3);
        end

        for (int i = 0; i < 40; i++) begin
            if (i >= 16 && i <= 22) begin
                drive("midrst", !(i >= 20 && i <= 22), 1000, i % 32, 1'b0, 1'b1, 0, 0, 1'b1, 0, 1'b0);
            end else begin
                drive("midrst", 1'b1, 1000, i % 32, i == 23, 1'b0, 0, 0, 1'b1, i % 32, i == 23);
            end
        end

        for (int w = 0; w < 20 && q.size() > 0; w++) @(posedge clk);
        if (q.size() > 0) begin
            cmp("drain", q.size(), 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
